uart_rx_param: RTL and testbench

Parametrised UART receive engine; next generation of the fixed 8-bit receiver in the uart_core datapath. Adds configurable word width and oversampling, runtime bit order (LSB/MSB first), optional even/odd parity, and break detection. Provides a one-entry output holding register with valid/ready handshake and overrun reporting. Feeds the SOF/frame parser that decodes host register read/write bursts.

---
 rtl/uart_rx_param.sv | 222 ++++++++++++++++++++++
 tb/tb_uart_rx_param.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parametrised oversampling UART receiver with one-entry holding register
module uart_rx_param #(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en_os_baud,
    input  logic                 serial_in_i,
    input  logic                 msb_first_i,
    input  logic                 parity_en_i,
    input  logic                 parity_odd_i,
    output logic [DATA_BITS-1:0] data_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic                 parity_err_o,
    output logic                 frame_err_o,
    output logic                 overrun_o,
    output logic                 break_o,
    output logic                 busy_o
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_END  = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_PARITY = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;
    localparam logic [2:0] S_WAIT   = 3'd5;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rxd;
    logic [2:0]             state_q, state_d;
    logic [TW-1:0]          tick_q, tick_d;
    logic [BW-1:0]          bit_q, bit_d;
    logic [DATA_BITS-1:0]   shreg_q, shreg_d;
    logic                   msb_q, msb_d;
    logic                   paren_q, paren_d;
    logic                   parodd_q, parodd_d;
    logic                   pbit_q, pbit_d;
    logic                   perr_pend_q, perr_pend_d;
    logic                   ferr_pend_q, ferr_pend_d;
    logic                   deliver_q, deliver_d;
    logic [DATA_BITS-1:0]   data_q, data_d;
    logic                   valid_q, valid_d;
    logic                   perr_q, perr_d;
    logic                   ferr_q, ferr_d;
    logic                   overrun_q, overrun_d;
    logic                   break_q, break_d;

    assign rxd = sync_q[SYNC_STAGES-1];

    always_comb begin
        state_d     = state_q;
        tick_d      = tick_q;
        bit_d       = bit_q;
        shreg_d     = shreg_q;
        msb_d       = msb_q;
        paren_d     = paren_q;
        parodd_d    = parodd_q;
        pbit_d      = pbit_q;
        perr_pend_d = perr_pend_q;
        ferr_pend_d = ferr_pend_q;
        deliver_d   = 1'b0;
        break_d     = 1'b0;
        overrun_d   = 1'b0;
        data_d      = data_q;
        valid_d     = valid_q;
        perr_d      = perr_q;
        ferr_d      = ferr_q;

        case (state_q)
            S_IDLE: begin
                if (!rxd) begin
                    state_d     = S_START;
                    tick_d      = '0;
                    msb_d       = msb_first_i;
                    paren_d     = parity_en_i;
                    parodd_d    = parity_odd_i;
                    pbit_d      = 1'b0;
                    perr_pend_d = 1'b0;
                end
            end
            S_START: begin
                if (en_os_baud) begin
                    if (tick_q == TICK_MID) begin
                        tick_d  = '0;
                        bit_d   = '0;
                        state_d = rxd ? S_IDLE : S_DATA;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (en_os_baud) begin
                    if (tick_q == TICK_END) begin
                        tick_d  = '0;
                        shreg_d = msb_q ? {shreg_q[DATA_BITS-2:0], rxd}
                                        : {rxd, shreg_q[DATA_BITS-1:1]};
                        if (bit_q == BIT_LAST) begin
                            state_d = paren_q ? S_PARITY : S_STOP;
                        end else begin
                            bit_d = bit_q + 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            S_PARITY: begin
                if (en_os_baud) begin
                    if (tick_q == TICK_END) begin
                        tick_d      = '0;
                        pbit_d      = rxd;
                        perr_pend_d = ((^shreg_q) ^ rxd) != parodd_q;
                        state_d     = S_STOP;
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            S_STOP: begin
                if (en_os_baud) begin
                    if (tick_q == TICK_END) begin
                        tick_d = '0;
                        if (rxd) begin
                            deliver_d   = 1'b1;
                            ferr_pend_d = 1'b0;
                            state_d     = S_IDLE;
                        end else if (shreg_q == '0 && (!paren_q || !pbit_q)) begin
                            break_d = 1'b1;
                            state_d = S_WAIT;
                        end else begin
                            deliver_d   = 1'b1;
                            ferr_pend_d = 1'b1;
                            state_d     = S_WAIT;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end
            S_WAIT: begin
                if (rxd) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A consumer pop and a fresh delivery in the same cycle reloads without a gap.
        if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end
        if (deliver_q) begin
            if (!valid_q || ready_i) begin
                data_d  = shreg_q;
                perr_d  = paren_q & perr_pend_q;
                ferr_d  = ferr_pend_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q      <= '1;
            state_q     <= S_IDLE;
            tick_q      <= '0;
            bit_q       <= '0;
            shreg_q     <= '0;
            msb_q       <= 1'b0;
            paren_q     <= 1'b0;
            parodd_q    <= 1'b0;
            pbit_q      <= 1'b0;
            perr_pend_q <= 1'b0;
            ferr_pend_q <= 1'b0;
            deliver_q   <= 1'b0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            perr_q      <= 1'b0;
            ferr_q      <= 1'b0;
            overrun_q   <= 1'b0;
            break_q     <= 1'b0;
        end else begin
            sync_q      <= {sync_q[SYNC_STAGES-2:0], serial_in_i};
            state_q     <= state_d;
            tick_q      <= tick_d;
            bit_q       <= bit_d;
            shreg_q     <= shreg_d;
            msb_q       <= msb_d;
            paren_q     <= paren_d;
            parodd_q    <= parodd_d;
            pbit_q      <= pbit_d;
            perr_pend_q <= perr_pend_d;
            ferr_pend_q <= ferr_pend_d;
            deliver_q   <= deliver_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            perr_q      <= perr_d;
            ferr_q      <= ferr_d;
            overrun_q   <= overrun_d;
            break_q     <= break_d;
        end
    end

    assign data_o       = data_q;
    assign valid_o      = valid_q;
    assign parity_err_o = perr_q;
    assign frame_err_o  = ferr_q;
    assign overrun_o    = overrun_q;
    assign break_o      = break_q;
    assign busy_o       = (state_q != S_IDLE);
endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - directed bench for uart_rx_param (8-bit and 9-bit instances)
module tb_uart_rx_param;
    localparam int BIT_CLKS = 64;   // 16 ticks per bit, one tick every 4 clocks

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] div;
    logic       en_os_baud;
    logic       msb_first_i, parity_en_i, parity_odd_i;
    logic       ser8, ser9, ready8, ready9;

    logic [7:0] data8;
    logic [8:0] data9;
    logic       valid8, perr8, ferr8, ovr8, brk8, busy8;
    logic       valid9, perr9, ferr9, ovr9, brk9, busy9;

    int tests_run = 0;
    int tests_failed = 0;
    int acc8 = 0, acc9 = 0, ovr_cnt8 = 0, brk_cnt8 = 0;
    logic [7:0] last8 = '0;
    logic [8:0] last9 = '0;
    logic       lperr8 = 1'b0, lferr8 = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) div <= rst ? 2'd0 : div + 2'd1;
    assign en_os_baud = (div == 2'd3);

    uart_rx_param #(.DATA_BITS(8), .OVERSAMPLE(16), .SYNC_STAGES(2)) dut8 (
        .clk(clk), .rst(rst), .en_os_baud(en_os_baud), .serial_in_i(ser8),
        .msb_first_i(msb_first_i), .parity_en_i(parity_en_i), .parity_odd_i(parity_odd_i),
        .data_o(data8), .valid_o(valid8), .ready_i(ready8), .parity_err_o(perr8),
        .frame_err_o(ferr8), .overrun_o(ovr8), .break_o(brk8), .busy_o(busy8));

    uart_rx_param #(.DATA_BITS(9), .OVERSAMPLE(16), .SYNC_STAGES(3)) dut9 (
        .clk(clk), .rst(rst), .en_os_baud(en_os_baud), .serial_in_i(ser9),
        .msb_first_i(msb_first_i), .parity_en_i(parity_en_i), .parity_odd_i(parity_odd_i),
        .data_o(data9), .valid_o(valid9), .ready_i(ready9), .parity_err_o(perr9),
        .frame_err_o(ferr9), .overrun_o(ovr9), .break_o(brk9), .busy_o(busy9));

    always @(negedge clk) begin
        if (valid8 && ready8) begin
            acc8++;
            last8  = data8;
            lperr8 = perr8;
            lferr8 = ferr8;
        end
        if (ovr8) ovr_cnt8++;
        if (brk8) brk_cnt8++;
        if (valid9 && ready9) begin
            acc9++;
            last9 = data9;
        end
    end

    task automatic set_line(input int sel, input logic v);
        if (sel == 9) ser9 = v;
        else ser8 = v;
    endtask

    task automatic hold(input int bits);
        repeat (bits * BIT_CLKS) @(posedge clk);
    endtask

    // stop_low > 0 holds the stop bit low for that many bit times before releasing
    task automatic send(input int sel, input logic [8:0] d, input int nb, input logic msb,
                        input logic pen, input logic pbit, input int toggle_idx,
                        input int stop_low);
        logic [11:0] bits;
        int n;
        bits = '0;
        bits[0] = 1'b0;
        for (int i = 0; i < nb; i++) bits[1+i] = msb ? d[nb-1-i] : d[i];
        n = nb + 1;
        if (pen) begin
            bits[n] = pbit;
            n++;
        end
        for (int i = 0; i < n; i++) begin
            if (i == toggle_idx) msb_first_i = ~msb_first_i;
            set_line(sel, bits[i]);
            hold(1);
        end
        if (stop_low > 0) begin
            set_line(sel, 1'b0);
            hold(stop_low);
        end
        set_line(sel, 1'b1);
        hold(2);
    endtask

    task automatic test_reset;
        tests_run++;
        if (valid8 !== 1'b0) begin tests_failed++; $display("FAIL reset_valid8 got %b want 0", valid8); end
        tests_run++;
        if (data8 !== 8'h00) begin tests_failed++; $display("FAIL reset_data8 got %h want 00", data8); end
        tests_run++;
        if ({perr8, ferr8, ovr8, brk8} !== 4'b0000) begin
            tests_failed++; $display("FAIL reset_status8 got %b want 0000", {perr8, ferr8, ovr8, brk8});
        end
        tests_run++;
        if (busy8 !== 1'b0 || busy9 !== 1'b0) begin
            tests_failed++; $display("FAIL reset_busy got %b%b want 00", busy8, busy9);
        end
        tests_run++;
        if (valid9 !== 1'b0 || data9 !== 9'h000) begin
            tests_failed++; $display("FAIL reset_dut9 got v=%b d=%h want v=0 d=000", valid9, data9);
        end
    endtask

    task automatic test_lsb;
        int a0 = acc8;
        send(8, 9'h091, 8, 1'b0, 1'b0, 1'b0, -1, 0);
        tests_run++;
        if (acc8 - a0 !== 1) begin tests_failed++; $display("FAIL lsb_count got %0d want 1", acc8 - a0); end
        tests_run++;
        if (last8 !== 8'h91) begin tests_failed++; $display("FAIL lsb_data got %h want 91", last8); end
        tests_run++;
        if ({lperr8, lferr8} !== 2'b00) begin
            tests_failed++; $display("FAIL lsb_err got %b want 00", {lperr8, lferr8});
        end
    endtask

    task automatic test_msb;
        int a0 = acc8;
        msb_first_i = 1'b1;
        send(8, 9'h091, 8, 1'b1, 1'b0, 1'b0, 3, 0);
        tests_run++;
        if (acc8 - a0 !== 1 || last8 !== 8'h91) begin
            tests_failed++; $display("FAIL msb_data got %h (n=%0d) want 91 (n=1)", last8, acc8 - a0);
        end
        msb_first_i = 1'b0;
    endtask

    task automatic test_parity;
        parity_en_i  = 1'b1;
        parity_odd_i = 1'b1;
        send(8, 9'h0AA, 8, 1'b0, 1'b1, 1'b0, -1, 0);
        tests_run++;
        if (last8 !== 8'hAA || lperr8 !== 1'b1) begin
            tests_failed++; $display("FAIL parity_bad got d=%h pe=%b want d=aa pe=1", last8, lperr8);
        end
        send(8, 9'h0AA, 8, 1'b0, 1'b1, 1'b1, -1, 0);
        tests_run++;
        if (last8 !== 8'hAA || lperr8 !== 1'b0) begin
            tests_failed++; $display("FAIL parity_good got d=%h pe=%b want d=aa pe=0", last8, lperr8);
        end
        parity_en_i  = 1'b0;
        parity_odd_i = 1'b0;
    endtask

    task automatic test_break;
        int a0 = acc8;
        int b0 = brk_cnt8;
        send(8, 9'h091, 8, 1'b0, 1'b0, 1'b0, -1, 20);
        tests_run++;
        if (acc8 - a0 !== 1 || last8 !== 8'h91 || lferr8 !== 1'b1) begin
            tests_failed++;
            $display("FAIL frame_err got n=%0d d=%h fe=%b want n=1 d=91 fe=1", acc8 - a0, last8, lferr8);
        end
        tests_run++;
        if (brk_cnt8 !== b0) begin tests_failed++; $display("FAIL frame_err_nobreak got %0d want 0", brk_cnt8 - b0); end
        a0 = acc8;
        ser8 = 1'b0;
        hold(20);
        ser8 = 1'b1;
        hold(2);
        tests_run++;
        if (brk_cnt8 - b0 !== 1) begin tests_failed++; $display("FAIL break_pulses got %0d want 1", brk_cnt8 - b0); end
        tests_run++;
        if (acc8 !== a0) begin tests_failed++; $display("FAIL break_nodata got %0d want 0", acc8 - a0); end
        send(8, 9'h0AA, 8, 1'b0, 1'b0, 1'b0, -1, 0);
        tests_run++;
        if (acc8 - a0 !== 1 || last8 !== 8'hAA || {lperr8, lferr8} !== 2'b00) begin
            tests_failed++;
            $display("FAIL after_break got n=%0d d=%h e=%b want n=1 d=aa e=00", acc8 - a0, last8, {lperr8, lferr8});
        end
    endtask

    task automatic test_overrun;
        int a0, o0;
        ready8 = 1'b0;
        o0 = ovr_cnt8;
        send(8, 9'h011, 8, 1'b0, 1'b0, 1'b0, -1, 0);
        send(8, 9'h022, 8, 1'b0, 1'b0, 1'b0, -1, 0);
        tests_run++;
        if (valid8 !== 1'b1 || data8 !== 8'h11) begin
            tests_failed++; $display("FAIL overrun_hold got v=%b d=%h want v=1 d=11", valid8, data8);
        end
        tests_run++;
        if (ovr_cnt8 - o0 !== 1) begin tests_failed++; $display("FAIL overrun_pulses got %0d want 1", ovr_cnt8 - o0); end
        a0 = acc8;
        @(posedge clk);
        #1 ready8 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        tests_run++;
        if (valid8 !== 1'b0 || acc8 - a0 !== 1 || last8 !== 8'h11) begin
            tests_failed++;
            $display("FAIL overrun_pop got v=%b n=%0d d=%h want v=0 n=1 d=11", valid8, acc8 - a0, last8);
        end
        a0 = acc8;
        ser8 = 1'b0;
        repeat (12) @(posedge clk);
        ser8 = 1'b1;
        hold(12);
        tests_run++;
        if (acc8 !== a0 || valid8 !== 1'b0 || busy8 !== 1'b0) begin
            tests_failed++;
            $display("FAIL glitch got n=%0d v=%b busy=%b want n=0 v=0 busy=0", acc8 - a0, valid8, busy8);
        end
    endtask

    task automatic test_nine_bit;
        int a0 = acc9;
        send(9, 9'h1A5, 9, 1'b0, 1'b0, 1'b0, -1, 0);
        tests_run++;
        if (acc9 - a0 !== 1 || last9 !== 9'h1A5) begin
            tests_failed++; $display("FAIL nine_lsb got %h (n=%0d) want 1a5 (n=1)", last9, acc9 - a0);
        end
        a0 = acc9;
        msb_first_i = 1'b1;
        send(9, 9'h1A5, 9, 1'b1, 1'b0, 1'b0, -1, 0);
        msb_first_i = 1'b0;
        tests_run++;
        if (acc9 - a0 !== 1 || last9 !== 9'h1A5) begin
            tests_failed++; $display("FAIL nine_msb got %h (n=%0d) want 1a5 (n=1)", last9, acc9 - a0);
        end
        a0 = acc9;
        ser9 = 1'b0;
        hold(4);
        ser9 = 1'b1;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        rst = 1'b0;
        @(negedge clk);
        tests_run++;
        if (valid9 !== 1'b0 || busy9 !== 1'b0) begin
            tests_failed++; $display("FAIL nine_rst got v=%b busy=%b want 0 0", valid9, busy9);
        end
        hold(12);
        tests_run++;
        if (acc9 !== a0) begin tests_failed++; $display("FAIL nine_rst_nodata got %0d want 0", acc9 - a0); end
        send(9, 9'h0C3, 9, 1'b0, 1'b0, 1'b0, -1, 0);
        tests_run++;
        if (acc9 - a0 !== 1 || last9 !== 9'h0C3) begin
            tests_failed++; $display("FAIL nine_after_rst got %h (n=%0d) want 0c3 (n=1)", last9, acc9 - a0);
        end
    endtask

    initial begin
        rst = 1'b1;
        msb_first_i = 1'b0;
        parity_en_i = 1'b0;
        parity_odd_i = 1'b0;
        ser8 = 1'b1;
        ser9 = 1'b1;
        ready8 = 1'b1;
        ready9 = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        test_reset();
        rst = 1'b0;
        hold(1);
        test_lsb();
        test_msb();
        test_parity();
        test_break();
        test_overrun();
        test_nine_bit();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
